// File: rtl/dmem_arb_pkg.sv
// Shared constants, PE indices and address-range helper for the dual-PE data memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_DEPTH = 1024;
  localparam int          DMEM_DW    = 32;
  localparam int          DMEM_AW    = 32;
  localparam int          DMEM_CNT_W = 16;

  localparam int PE0 = 0;
  localparam int PE1 = 1;

  function automatic logic in_range(input logic [DMEM_AW-1:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dmem_resp_slice.sv
// Per-PE response register: captures rvalid/rdata/err on grant, one-cycle latency.
// No backpressure: a response is a single-cycle pulse that the PE must take.
module dmem_resp_slice
  import dmem_arb_pkg::*;
#(
  parameter int DW = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_gnt,
  input  logic          i_we,
  input  logic          i_in_rng,
  input  logic [DW-1:0] i_mem_rd,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
      o_err    <= 1'b0;
    end else if (i_gnt) begin
      o_rvalid <= 1'b1;
      // Writes and out-of-range accesses return zero so stale data never leaks.
      o_rdata  <= (!i_we && i_in_rng) ? i_mem_rd : '0;
      o_err    <= !i_in_rng;
    end else begin
      o_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_dual_pe_arbiter.sv
// Two-PE front end to a dual-port memory: combinational grant, same-address write hazards
// serialised by a round-robin bit; responses one cycle after grant; requests hold until granted.
module dmem_dual_pe_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH,
  parameter int          DW    = DMEM_DW,
  parameter int          AW    = DMEM_AW,
  parameter int          CNT_W = DMEM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pe_req,
  input  logic [1:0]       pe_we,
  input  logic [AW-1:0]    pe0_addr,
  input  logic [AW-1:0]    pe1_addr,
  input  logic [DW-1:0]    pe0_wdata,
  input  logic [DW-1:0]    pe1_wdata,
  output logic [1:0]       pe_gnt,
  output logic [1:0]       pe_rvalid,
  output logic [DW-1:0]    pe0_rdata,
  output logic [DW-1:0]    pe1_rdata,
  output logic [1:0]       pe_err,
  output logic             mem_we1,
  output logic             mem_we2,
  output logic [AW-1:0]    mem_a1,
  output logic [AW-1:0]    mem_a2,
  output logic [DW-1:0]    mem_wd1,
  output logic [DW-1:0]    mem_wd2,
  input  logic [DW-1:0]    mem_rd1,
  input  logic [DW-1:0]    mem_rd2,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             w_rng0;
  logic             w_rng1;
  logic             w_conflict;
  logic [1:0]       w_gnt;
  logic             r_prio;
  logic [CNT_W-1:0] r_cnt;

  assign w_rng0     = in_range(pe0_addr, DEPTH);
  assign w_rng1     = in_range(pe1_addr, DEPTH);
  assign w_conflict = (&pe_req) && (pe0_addr == pe1_addr) && (|pe_we);

  // Grant is forced low while reset is held so no write can slip through.
  always_comb begin
    w_gnt = pe_req;
    if (w_conflict) begin
      w_gnt = r_prio ? 2'b10 : 2'b01;
    end
    if (!rst) begin
      w_gnt = 2'b00;
    end
  end

  assign pe_gnt  = w_gnt;
  assign mem_we1 = w_gnt[PE0] & pe_we[PE0] & w_rng0;
  assign mem_we2 = w_gnt[PE1] & pe_we[PE1] & w_rng1;
  assign mem_a1  = pe0_addr;
  assign mem_a2  = pe1_addr;
  assign mem_wd1 = pe0_wdata;
  assign mem_wd2 = pe1_wdata;

  // Priority passes to the loser so a held request wins the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio <= 1'b0;
      r_cnt  <= '0;
    end else if (w_conflict) begin
      r_prio <= ~r_prio;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign conflict_cnt = r_cnt;

  dmem_resp_slice #(.DW(DW)) u_resp0 (
    .clk      (clk),
    .rst_n    (rst),
    .i_gnt    (w_gnt[PE0]),
    .i_we     (pe_we[PE0]),
    .i_in_rng (w_rng0),
    .i_mem_rd (mem_rd1),
    .o_rvalid (pe_rvalid[PE0]),
    .o_rdata  (pe0_rdata),
    .o_err    (pe_err[PE0])
  );

  dmem_resp_slice #(.DW(DW)) u_resp1 (
    .clk      (clk),
    .rst_n    (rst),
    .i_gnt    (w_gnt[PE1]),
    .i_we     (pe_we[PE1]),
    .i_in_rng (w_rng1),
    .i_mem_rd (mem_rd2),
    .o_rvalid (pe_rvalid[PE1]),
    .o_rdata  (pe1_rdata),
    .o_err    (pe_err[PE1])
  );

endmodule
